alumul_iter_mul_e: RTL

- Execute-stage iterative multiplier implementing RV32M MUL, MULH, MULHSU and MULHU.
- Sits directly downstream of the forwarding unit. It consumes alumul_data1_sel_e and alumul_forward_sel_e to choose its operands, either register-file data or the M-stage forwarded value.
- It stalls the pipeline while computing and presents a one-cycle done pulse with the result for the E/M register.

---
 rtl/alumul_iter_mul_e.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alumul_iter_mul_e.sv
// alumul_iter_mul_e: E-stage radix-2 iterative multiplier for RV32M
// MUL/MULH/MULHSU/MULHU. Operands are taken from the forwarding mux on the
// accept edge and stored as unsigned magnitudes. One shift-add step runs per
// BUSY cycle, and the sign is applied on the final step. The pipeline is held
// while the unit works, and a one-cycle done pulse presents the registered result.
module alumul_iter_mul_e #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_e,
  input  logic [1:0]      mul_op_e,
  input  logic [XLEN-1:0] rs1_data_e,
  input  logic [XLEN-1:0] rs2_data_e,
  input  logic [XLEN-1:0] fwd_data_m,
  input  logic            alumul_data1_sel_e,
  input  logic            alumul_forward_sel_e,
  input  logic            flush_e,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            stall_o
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Control captured with the operands; it stays fixed for the whole operation.
  typedef struct packed {
    logic [1:0] op;
    logic       neg;
  } mul_ctl_t;

  state_t             r_state, w_state_nxt;
  mul_ctl_t           r_ctl;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_mcand;
  logic [XLEN-1:0]    r_mplier;
  logic [XLEN-1:0]    r_result;

  logic [XLEN-1:0]    w_op1, w_op2, w_mag1, w_mag2;
  logic               w_s1, w_s2, w_neg1, w_neg2;
  logic               w_accept, w_last;
  logic [XLEN:0]      w_sum;
  logic [2*XLEN-1:0]  w_acc_step, w_prod;
  logic [XLEN-1:0]    w_res;

  // Operand mux and sign handling. Negating the most negative value gives
  // 0x80000000, which is the correct unsigned magnitude.
  always_comb begin
    w_op1  = alumul_data1_sel_e   ? fwd_data_m : rs1_data_e;
    w_op2  = alumul_forward_sel_e ? fwd_data_m : rs2_data_e;
    w_s1   = (mul_op_e == OP_MULH) || (mul_op_e == OP_MULHSU);
    w_s2   = (mul_op_e == OP_MULH);
    w_neg1 = w_s1 & w_op1[XLEN-1];
    w_neg2 = w_s2 & w_op2[XLEN-1];
    w_mag1 = w_neg1 ? (~w_op1 + 1'b1) : w_op1;
    w_mag2 = w_neg2 ? (~w_op2 + 1'b1) : w_op2;
  end

  assign w_accept = (r_state == S_IDLE) && start_e && !flush_e;
  assign w_last   = (r_state == S_BUSY) && !flush_e && (r_cnt == CNT_W'(XLEN-1));

  // One shift-add step. The carry out of the upper-half add shifts into the
  // top bit. The signed result is formed here, so the final step can load
  // result_o for the DONE cycle.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    w_acc_step = {w_sum, r_acc[XLEN-1:1]};
    w_prod     = r_ctl.neg ? (~w_acc_step + 1'b1) : w_acc_step;
    w_res      = (r_ctl.op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and status outputs. DONE always returns to IDLE, because
  // the instruction that just finished still drives start_e in that cycle.
  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    stall_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_accept;
        if (w_accept) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        busy_o  = 1'b1;
        stall_o = 1'b1;
        if (flush_e)                          w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_W'(XLEN-1))     w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, and step while BUSY. A flush freezes the
  // datapath, and the next accept reinitialises it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl    <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_ctl.op  <= mul_op_e;
      r_ctl.neg <= w_neg1 ^ w_neg2;
      r_mcand   <= w_mag1;
      r_mplier  <= w_mag2;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else if (r_state == S_BUSY && !flush_e) begin
      r_acc    <= w_acc_step;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_result <= w_res;
    end
  end

  assign result_o = r_result;

endmodule
